// File: rtl/vga_coord_gen_if.sv
// Drawer/DAC-side bundle of the VGA coordinate generator: coordinates out, merged colour back, pins out.
// Optional iTest_Mode input exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_coord_gen_if;
  logic [10:0] oCoord_X;
  logic [10:0] oCoord_Y;
  logic [7:0]  mVGA_RGB;
  logic        oVGA_HS;
  logic        oVGA_VS;
  logic        oVGA_BLANK_N;
  logic [7:0]  oVGA_R;
  logic [7:0]  oVGA_G;
  logic [7:0]  oVGA_B;
  logic        oFrame_Start;
  logic        oVBlank_Start;
`ifdef VGA_TEST_PATTERN_EN
  logic        iTest_Mode;

  modport master (
    output oCoord_X, oCoord_Y, oVGA_HS, oVGA_VS, oVGA_BLANK_N,
    output oVGA_R, oVGA_G, oVGA_B, oFrame_Start, oVBlank_Start,
    input  mVGA_RGB, iTest_Mode
  );
  modport slave (
    input  oCoord_X, oCoord_Y, oVGA_HS, oVGA_VS, oVGA_BLANK_N,
    input  oVGA_R, oVGA_G, oVGA_B, oFrame_Start, oVBlank_Start,
    output mVGA_RGB, iTest_Mode
  );
`else
  modport master (
    output oCoord_X, oCoord_Y, oVGA_HS, oVGA_VS, oVGA_BLANK_N,
    output oVGA_R, oVGA_G, oVGA_B, oFrame_Start, oVBlank_Start,
    input  mVGA_RGB
  );
  modport slave (
    input  oCoord_X, oCoord_Y, oVGA_HS, oVGA_VS, oVGA_BLANK_N,
    input  oVGA_R, oVGA_G, oVGA_B, oFrame_Start, oVBlank_Start,
    output mVGA_RGB
  );
`endif
endinterface

// File: rtl/vga_coord_gen.sv
// VGA timing/coordinate master: raw counters to the drawers, sync/blank/RGB to the DAC two cycles later.
// Optional VGA_TEST_PATTERN_EN adds an 8-colour-bar source selected by iTest_Mode.
module vga_coord_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic            CLK,
  input  logic            RESETn,
  input  logic            iPix_En,
  vga_coord_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_ACT_C  = 11'(H_ACTIVE);
  localparam logic [10:0] H_LAST_C = 11'(H_TOTAL - 1);
  localparam logic [10:0] HS_BEG_C = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END_C = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_C  = 11'(V_ACTIVE);
  localparam logic [10:0] V_LAST_C = 11'(V_TOTAL - 1);
  localparam logic [10:0] VS_BEG_C = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END_C = 11'(V_ACTIVE + V_FP + V_SYNC);

  function automatic logic [7:0] expand3(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  function automatic logic [7:0] expand2(input logic [1:0] c);
    return {4{c}};
  endfunction

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [10:0] BAR_W_C = 11'(H_ACTIVE / 8);

  function automatic logic [7:0] bar_color(input logic [2:0] bar);
    case (bar)
      3'd0:    return 8'hE0;
      3'd1:    return 8'h1C;
      3'd2:    return 8'h03;
      3'd3:    return 8'hFC;
      3'd4:    return 8'hE3;
      3'd5:    return 8'h1F;
      3'd6:    return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction
`endif

  logic [10:0] h_p0, v_p0;
  logic [10:0] h_nxt, v_nxt;

  always_comb begin
    h_nxt = h_p0 + 11'd1;
    v_nxt = v_p0;
    if (h_p0 == H_LAST_C) begin
      h_nxt = '0;
      v_nxt = (v_p0 == V_LAST_C) ? '0 : v_p0 + 11'd1;
    end
  end

  // Stage 0: counters and frame pulses; pulses clear on every CLK so they never stretch
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      h_p0              <= '0;
      v_p0              <= '0;
      vga.oFrame_Start  <= 1'b0;
      vga.oVBlank_Start <= 1'b0;
    end else begin
      vga.oFrame_Start  <= 1'b0;
      vga.oVBlank_Start <= 1'b0;
      if (iPix_En) begin
        h_p0              <= h_nxt;
        v_p0              <= v_nxt;
        vga.oFrame_Start  <= (h_nxt == '0) && (v_nxt == '0);
        vga.oVBlank_Start <= (h_nxt == '0) && (v_nxt == V_ACT_C);
      end
    end
  end

  assign vga.oCoord_X = h_p0;
  assign vga.oCoord_Y = v_p0;

  logic hs_p1, vs_p1, vld_p1;
`ifdef VGA_TEST_PATTERN_EN
  logic [10:0] h_p1;
`endif

  // Stage 1: timing flags delayed to meet the drawers' registered colour
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      vld_p1 <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
      h_p1   <= '0;
`endif
    end else if (iPix_En) begin
      hs_p1  <= (h_p0 >= HS_BEG_C) && (h_p0 < HS_END_C);
      vs_p1  <= (v_p0 >= VS_BEG_C) && (v_p0 < VS_END_C);
      vld_p1 <= (h_p0 < H_ACT_C) && (v_p0 < V_ACT_C);
`ifdef VGA_TEST_PATTERN_EN
      h_p1   <= h_p0;
`endif
    end
  end

  logic [7:0] rgb_p1;

  always_comb begin
    rgb_p1 = vga.mVGA_RGB;
`ifdef VGA_TEST_PATTERN_EN
    if (vga.iTest_Mode) rgb_p1 = bar_color(3'(h_p1 / BAR_W_C));
`endif
  end

  // Stage 2: DAC pins; sync carried as "asserted" internally, polarity applied here
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      vga.oVGA_HS      <= ~SYNC_POL;
      vga.oVGA_VS      <= ~SYNC_POL;
      vga.oVGA_BLANK_N <= 1'b0;
      vga.oVGA_R       <= '0;
      vga.oVGA_G       <= '0;
      vga.oVGA_B       <= '0;
    end else if (iPix_En) begin
      vga.oVGA_HS      <= hs_p1 ? SYNC_POL : ~SYNC_POL;
      vga.oVGA_VS      <= vs_p1 ? SYNC_POL : ~SYNC_POL;
      vga.oVGA_BLANK_N <= vld_p1;
      vga.oVGA_R       <= vld_p1 ? expand3(rgb_p1[7:5]) : 8'h00;
      vga.oVGA_G       <= vld_p1 ? expand3(rgb_p1[4:2]) : 8'h00;
      vga.oVGA_B       <= vld_p1 ? expand2(rgb_p1[1:0]) : 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_coord_gen.sv
// Bench for vga_coord_gen with a reduced raster (25x15) so whole frames fit in a short run.
// A position-counting reference model is compared against every output on every falling edge.
module tb_vga_coord_gen;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;   // 25
  localparam int VT = VA + VF + VS + VB;   // 15
  localparam int FRAME = HT * VT;          // 375

  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  logic iPix_En = 1'b0;
  int   mode = 0;

  vga_coord_gen_if vif();

  vga_coord_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .CLK(CLK),
    .RESETn(RESETn),
    .iPix_En(iPix_En),
    .vga(vif)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] drawer_fn(input int x, input int y, input int m);
    case (m)
      0:       return 8'h44;
      1:       return (x == 5) ? 8'hFF : 8'h00;
      default: return 8'((x * 7) + (y * 13) + 3);
    endcase
  endfunction

  // Drawer: registered colour for the coordinate currently presented
  always @(posedge CLK or negedge RESETn) begin
    if (!RESETn) vif.mVGA_RGB <= 8'h00;
    else if (iPix_En) vif.mVGA_RGB <= drawer_fn(int'(vif.oCoord_X), int'(vif.oCoord_Y), mode);
  end

`ifdef VGA_TEST_PATTERN_EN
  initial vif.iTest_Mode = 1'b0;
`endif

  // Reference model: n = enabled pixel clocks since reset release
  int n = 0;
  bit last_en = 1'b0;
  always @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      n <= 0;
      last_en <= 1'b0;
    end else begin
      last_en <= iPix_En;
      if (iPix_En) n <= n + 1;
    end
  end

  always @(negedge CLK) begin
    int m, xm, ym;
    bit act;
    logic [7:0] c, er, eg, eb;
    logic ehs, evs;
    chk("coord_x", 32'(vif.oCoord_X), 32'(n % HT));
    chk("coord_y", 32'(vif.oCoord_Y), 32'((n / HT) % VT));
    chk("frame_start", 32'(vif.oFrame_Start), 32'(last_en && n > 0 && (n % FRAME) == 0));
    chk("vblank_start", 32'(vif.oVBlank_Start), 32'(last_en && (n % FRAME) == HT * VA));
    if (n < 2) begin
      ehs = 1'b1; evs = 1'b1; act = 1'b0; er = 0; eg = 0; eb = 0;
    end else begin
      m  = n - 2;
      xm = m % HT;
      ym = (m / HT) % VT;
      act = (xm < HA) && (ym < VA);
      ehs = !((xm >= HA + HF) && (xm < HA + HF + HS));
      evs = !((ym >= VA + VF) && (ym < VA + VF + VS));
      c  = drawer_fn(xm, ym, mode);
      er = act ? 8'((c[7:5] * 36) + (c[7:5] >> 1)) : 8'h00;
      eg = act ? 8'((c[4:2] * 36) + (c[4:2] >> 1)) : 8'h00;
      eb = act ? 8'(c[1:0] * 8'h55) : 8'h00;
    end
    chk("hs", 32'(vif.oVGA_HS), 32'(ehs));
    chk("vs", 32'(vif.oVGA_VS), 32'(evs));
    chk("blank_n", 32'(vif.oVGA_BLANK_N), 32'(act));
    chk("r", 32'(vif.oVGA_R), 32'(er));
    chk("g", 32'(vif.oVGA_G), 32'(eg));
    chk("b", 32'(vif.oVGA_B), 32'(eb));
  end

  // Runs `len` clocks after release with iPix_En=1 and pins first pulse positions plus selected pixels
  task automatic run_lit(input int len, input int m);
    int fs_at, vb_at;
    fs_at = -1; vb_at = -1;
    for (int k = 1; k <= len; k++) begin
      @(posedge CLK); #1;
      if (vif.oFrame_Start && fs_at < 0) fs_at = k;
      if (vif.oVBlank_Start && vb_at < 0) vb_at = k;
      if (m == 0 && k == 2) begin
        chk("lit_r_44", 32'(vif.oVGA_R), 32'h49);
        chk("lit_g_44", 32'(vif.oVGA_G), 32'h24);
        chk("lit_b_44", 32'(vif.oVGA_B), 32'h00);
        chk("lit_blank_first", 32'(vif.oVGA_BLANK_N), 32'h1);
      end
      if (m == 0 && k == 19) chk("lit_hs_before", 32'(vif.oVGA_HS), 32'h1);
      if (m == 0 && k == 20) chk("lit_hs_start", 32'(vif.oVGA_HS), 32'h0);
      if (m == 0 && k == 251) chk("lit_vs_before", 32'(vif.oVGA_VS), 32'h1);
      if (m == 0 && k == 252) chk("lit_vs_start", 32'(vif.oVGA_VS), 32'h0);
      if (m == 1 && k == 6) chk("lit_x4_dark", 32'(vif.oVGA_R), 32'h00);
      if (m == 1 && k == 7) chk("lit_x5_white", 32'({vif.oVGA_R, vif.oVGA_G, vif.oVGA_B}), 32'hFFFFFF);
      if (m == 1 && k == 8) chk("lit_x6_dark", 32'(vif.oVGA_G), 32'h00);
      if (m == 1 && k == 32) chk("lit_line1_white", 32'(vif.oVGA_B), 32'hFF);
    end
    chk("lit_first_vblank", 32'(vb_at), 32'(HT * VA));
    chk("lit_first_frame", 32'(fs_at), 32'(FRAME));
  endtask

  initial begin
    bit found;
    RESETn = 1'b0; iPix_En = 1'b0; mode = 0;
    repeat (3) @(negedge CLK);
    chk("lit_reset_x", 32'(vif.oCoord_X), 32'h0);
    chk("lit_reset_hs", 32'(vif.oVGA_HS), 32'h1);
    chk("lit_reset_vs", 32'(vif.oVGA_VS), 32'h1);

    // Constant colour, two frames
    @(negedge CLK); RESETn = 1'b1; iPix_En = 1'b1;
    run_lit(400, 0);
    repeat (400) @(negedge CLK);

    // Asynchronous reset in the middle of a frame
    found = 1'b0;
    for (int k = 0; k < 1000 && !found; k++) begin
      @(negedge CLK);
      if (vif.oCoord_X == 11'd10 && vif.oCoord_Y == 11'd5) found = 1'b1;
    end
    chk("reach_10_5", 32'(found), 32'h1);
    #2 RESETn = 1'b0;
    #1;
    chk("async_x", 32'(vif.oCoord_X), 32'h0);
    chk("async_y", 32'(vif.oCoord_Y), 32'h0);
    chk("async_rgb", 32'({vif.oVGA_R, vif.oVGA_G, vif.oVGA_B}), 32'h0);
    chk("async_blank", 32'(vif.oVGA_BLANK_N), 32'h0);
    mode = 1;
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;
    run_lit(400, 1);

    // Pixel enable toggling every clock: line takes twice as long
    @(negedge CLK); RESETn = 1'b0; mode = 2;
    @(negedge CLK); RESETn = 1'b1; iPix_En = 1'b1;
    for (int k = 0; k < 49; k++) begin
      @(negedge CLK); iPix_En = ~iPix_En;
    end
    @(negedge CLK);
    chk("lit_toggle_x", 32'(vif.oCoord_X), 32'h0);
    chk("lit_toggle_y", 32'(vif.oCoord_Y), 32'h1);
    iPix_En = ~iPix_En;
    for (int k = 0; k < 800; k++) begin
      @(negedge CLK); iPix_En = ~iPix_En;
    end

    @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
